// File: rtl/pe_pkg.sv
// pe_pkg: shared types and constants for the posit PE datapath.
//
// Contents:
//   mul_split_t               lane-split selector for the default 4-partition multiplier
//   MUL_SPLIT_FULL/HALF/QUARTER  1, 2 or 4 independent lanes
//   precision_config_e        PE precision modes
//   mul_split_from_precision  maps a precision mode onto a multiplier split
package pe_pkg;

  // Width of the split selector for N_PARTS=4: log2(4)+2 = 4 codes -> 2 bits.
  // Wider multiplier instances size their own split port.
  localparam int MUL_SPLIT_W = 2;

  typedef logic [MUL_SPLIT_W-1:0] mul_split_t;

  localparam mul_split_t MUL_SPLIT_FULL    = 2'd0;  // one 32b x 32b lane
  localparam mul_split_t MUL_SPLIT_HALF    = 2'd1;  // two 16b x 16b lanes
  localparam mul_split_t MUL_SPLIT_QUARTER = 2'd2;  // four 8b x 8b lanes

  typedef enum logic [1:0] {
    PRECISION_CONFIG_32B = 2'd0,
    PRECISION_CONFIG_16B = 2'd1,
    PRECISION_CONFIG_8B  = 2'd2
  } precision_config_e;

  function automatic mul_split_t mul_split_from_precision(input precision_config_e cfg);
    case (cfg)
      PRECISION_CONFIG_32B: return MUL_SPLIT_FULL;
      PRECISION_CONFIG_16B: return MUL_SPLIT_HALF;
      PRECISION_CONFIG_8B:  return MUL_SPLIT_QUARTER;
      default:              return MUL_SPLIT_FULL;
    endcase
  endfunction

endpackage

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: one valid/ready register slice.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset (clears valid and payload)
//   in_valid   upstream beat valid
//   in_ready   slice can take a beat (empty, or emptying this cycle)
//   in_data    upstream payload
//   out_valid  slice holds a beat
//   out_ready  downstream takes the held beat this cycle
//   out_data   held payload; stable while out_valid && !out_ready
module elastic_pipe_reg #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] data_q, data_d;

  // Full throughput: a full slice still accepts when its beat leaves.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
    end
    if (in_ready && in_valid) begin
      data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/multiplier_decomposable_pipe.sv
// multiplier_decomposable_pipe: pipelined unsigned multiplier whose operands
// split into 2^split independent lanes.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid/in_ready     operand handshake
//   in0, in1              operands, lane k at [k*LW +: LW], LW = TOTAL_LEN>>split
//   in_split              log2(lane count); > log2(N_PARTS) flags an error
//   in_tag                sideband returned with the result
//   out_valid/out_ready   result handshake
//   out_prod              lane k product at [k*2*LW +: 2*LW]
//   out_split, out_tag    split and tag of the result beat
//   out_err               result beat carried an illegal split (out_prod = 0)
//
// Pipeline contents by PIPE_STAGES:
//   3: gated operands | partial products | lane products
//   2: partial products | lane products
//   1: lane products
module multiplier_decomposable_pipe
  import pe_pkg::*;
#(
  parameter int EACH_PART_LEN = 8,
  parameter int N_PARTS       = 4,
  parameter int PIPE_STAGES   = 2,
  parameter int TAG_W         = 4,
  localparam int TOTAL_LEN    = EACH_PART_LEN * N_PARTS,
  localparam int LOG2N        = $clog2(N_PARTS),
  localparam int SPLIT_W      = $clog2(LOG2N + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_LEN-1:0]   in0,
  input  logic [TOTAL_LEN-1:0]   in1,
  input  logic [SPLIT_W-1:0]     in_split,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*TOTAL_LEN-1:0] out_prod,
  output logic [SPLIT_W-1:0]     out_split,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err
);

  localparam int PP_W     = 2 * EACH_PART_LEN;
  localparam int N_PP     = N_PARTS * N_PARTS;
  localparam int PP_ALL_W = N_PP * PP_W;
  localparam int PROD_W   = 2 * TOTAL_LEN;
  localparam int META_W   = TAG_W + SPLIT_W + 1;   // {tag, split, err}

  // Partitions i and j feed the same lane when i/PPL == j/PPL, PPL = 2^(LOG2N-split).
  function automatic logic same_lane(input int i, input int j, input logic [SPLIT_W-1:0] sp);
    int sh;
    if (sp > SPLIT_W'(LOG2N)) begin
      return 1'b0;
    end
    sh = LOG2N - int'(sp);
    return (i >> sh) == (j >> sh);
  endfunction

  // ---------------------------------------------------------------------------
  // Input side: illegal splits travel with zeroed operands so the product is 0.
  // ---------------------------------------------------------------------------
  logic                 in_err;
  logic [TOTAL_LEN-1:0] in_a_g, in_b_g;
  logic [META_W-1:0]    in_meta;

  assign in_err  = in_split > SPLIT_W'(LOG2N);
  assign in_a_g  = in_err ? '0 : in0;
  assign in_b_g  = in_err ? '0 : in1;
  assign in_meta = {in_tag, in_split, in_err};

  // ---------------------------------------------------------------------------
  // Partial products, gated to zero across lane boundaries.
  // ---------------------------------------------------------------------------
  logic [TOTAL_LEN-1:0]          pp_src_a, pp_src_b;
  logic [SPLIT_W-1:0]            pp_src_split;
  logic [N_PP-1:0][PP_W-1:0]     pp_comb;

  for (genvar gi = 0; gi < N_PARTS; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < N_PARTS; gj++) begin : g_pp_col
      assign pp_comb[gi*N_PARTS+gj] =
        same_lane(gi, gj, pp_src_split)
          ? (PP_W'(pp_src_a[gi*EACH_PART_LEN +: EACH_PART_LEN]) *
             PP_W'(pp_src_b[gj*EACH_PART_LEN +: EACH_PART_LEN]))
          : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane reduction. A term's in-lane offset (i+j-2*k*PPL)*EACH_PART_LEN plus
  // the lane base k*2*LW is simply (i+j)*EACH_PART_LEN, so every surviving
  // term can be placed at its absolute position and all terms summed in one
  // adder tree. Each lane total fits its 2*LW field exactly, so no carry ever
  // reaches the next lane and the split does not enter the reduction.
  // ---------------------------------------------------------------------------
  logic [N_PP-1:0][PP_W-1:0]   red_src_pp;
  logic [N_PP-1:0][PROD_W-1:0] red_term;
  logic [PROD_W-1:0]           prod_comb;

  for (genvar gi = 0; gi < N_PARTS; gi++) begin : g_red_row
    for (genvar gj = 0; gj < N_PARTS; gj++) begin : g_red_col
      assign red_term[gi*N_PARTS+gj] =
        PROD_W'(red_src_pp[gi*N_PARTS+gj]) << ((gi + gj) * EACH_PART_LEN);
    end
  end

  always_comb begin
    prod_comb = '0;
    for (int k = 0; k < N_PP; k++) begin
      prod_comb = prod_comb + red_term[k];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers.
  // ---------------------------------------------------------------------------
  logic                     first_ready;
  logic                     last_valid;
  logic [META_W+PROD_W-1:0] last_data;

  if (PIPE_STAGES == 1) begin : g_one
    assign pp_src_a     = in_a_g;
    assign pp_src_b     = in_b_g;
    assign pp_src_split = in_split;
    assign red_src_pp   = pp_comb;

    elastic_pipe_reg #(.PAYLOAD_W(META_W + PROD_W)) u_st_prod (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (first_ready),
      .in_data   ({in_meta, prod_comb}),
      .out_valid (last_valid),
      .out_ready (out_ready),
      .out_data  (last_data)
    );
  end else if (PIPE_STAGES == 2) begin : g_two
    logic                       pp_valid, prod_ready;
    logic [META_W+PP_ALL_W-1:0] pp_data;

    assign pp_src_a     = in_a_g;
    assign pp_src_b     = in_b_g;
    assign pp_src_split = in_split;
    assign red_src_pp   = pp_data[PP_ALL_W-1:0];

    elastic_pipe_reg #(.PAYLOAD_W(META_W + PP_ALL_W)) u_st_pp (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (first_ready),
      .in_data   ({in_meta, pp_comb}),
      .out_valid (pp_valid),
      .out_ready (prod_ready),
      .out_data  (pp_data)
    );

    elastic_pipe_reg #(.PAYLOAD_W(META_W + PROD_W)) u_st_prod (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (pp_valid),
      .in_ready  (prod_ready),
      .in_data   ({pp_data[META_W+PP_ALL_W-1 -: META_W], prod_comb}),
      .out_valid (last_valid),
      .out_ready (out_ready),
      .out_data  (last_data)
    );
  end else begin : g_three
    logic                          op_valid, pp_ready, pp_valid, prod_ready;
    logic [META_W+2*TOTAL_LEN-1:0] op_data;
    logic [META_W+PP_ALL_W-1:0]    pp_data;

    assign pp_src_a     = op_data[2*TOTAL_LEN-1:TOTAL_LEN];
    assign pp_src_b     = op_data[TOTAL_LEN-1:0];
    assign pp_src_split = op_data[2*TOTAL_LEN+1 +: SPLIT_W];
    assign red_src_pp   = pp_data[PP_ALL_W-1:0];

    elastic_pipe_reg #(.PAYLOAD_W(META_W + 2*TOTAL_LEN)) u_st_op (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (first_ready),
      .in_data   ({in_meta, in_a_g, in_b_g}),
      .out_valid (op_valid),
      .out_ready (pp_ready),
      .out_data  (op_data)
    );

    elastic_pipe_reg #(.PAYLOAD_W(META_W + PP_ALL_W)) u_st_pp (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (op_valid),
      .in_ready  (pp_ready),
      .in_data   ({op_data[META_W+2*TOTAL_LEN-1 -: META_W], pp_comb}),
      .out_valid (pp_valid),
      .out_ready (prod_ready),
      .out_data  (pp_data)
    );

    elastic_pipe_reg #(.PAYLOAD_W(META_W + PROD_W)) u_st_prod (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (pp_valid),
      .in_ready  (prod_ready),
      .in_data   ({pp_data[META_W+PP_ALL_W-1 -: META_W], prod_comb}),
      .out_valid (last_valid),
      .out_ready (out_ready),
      .out_data  (last_data)
    );
  end

  // ---------------------------------------------------------------------------
  // Outputs. in_ready is forced low while reset is asserted.
  // ---------------------------------------------------------------------------
  assign in_ready  = rst_n && first_ready;
  assign out_valid = last_valid;
  assign out_prod  = last_data[PROD_W-1:0];
  assign out_err   = last_data[PROD_W];
  assign out_split = last_data[PROD_W+1 +: SPLIT_W];
  assign out_tag   = last_data[PROD_W+1+SPLIT_W +: TAG_W];

endmodule

// File: tb/tb_multiplier_decomposable_pipe.sv
module tb_multiplier_decomposable_pipe;
  import pe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in0 = '0, in1 = '0;
  logic [1:0]  in_split = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_prod;
  logic [1:0]  out_split;
  logic [3:0]  out_tag;
  logic        out_err;

  multiplier_decomposable_pipe #(
    .EACH_PART_LEN (8),
    .N_PARTS       (4),
    .PIPE_STAGES   (2),
    .TAG_W         (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .in_split  (in_split),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_split (out_split),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Reference: independent lane-by-lane multiply.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] sp);
    logic [63:0] r;
    logic [63:0] m, x, y;
    int lw;
    r = '0;
    if (sp > 2'd2) return '0;
    lw = 32 >> sp;
    m  = (64'd1 << lw) - 64'd1;
    for (int k = 0; k < (1 << sp); k++) begin
      x = (64'(a) >> (k * lw)) & m;
      y = (64'(b) >> (k * lw)) & m;
      r = r | ((x * y) << (k * 2 * lw));
    end
    return r;
  endfunction

  typedef struct {
    logic [63:0] prod;
    logic [1:0]  split;
    logic [3:0]  tag;
    logic        err;
    int          due;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] cur_exp_prod = '0;
  logic        cur_exp_err  = 1'b0;
  bit          lat_en       = 1'b1;

  // Scoreboard: push on input transfer, pop/compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready)
        sb.push_back('{cur_exp_prod, in_split, in_tag, cur_exp_err, cyc + 2, lat_en});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          $display("out tag=%0d split=%0d err=%b prod=%h", out_tag, out_split, out_err, out_prod);
          check_eq("prod",  out_prod,         e.prod);
          check_eq("split", 64'(out_split),   64'(e.split));
          check_eq("tag",   64'(out_tag),     64'(e.tag));
          check_eq("err",   64'(out_err),     64'(e.err));
          if (e.lat) check_eq("latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sp,
                      input logic [3:0] tag, input logic [63:0] exp_prod);
    in_valid = 1'b1;
    in0 = a; in1 = b; in_split = sp; in_tag = tag;
    cur_exp_prod = exp_prod;
    cur_exp_err  = (sp > 2'd2);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n > 50) begin
        check_eq("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] bp_a(input int t);
    return 32'h0101_0101 * (t + 3);
  endfunction

  function automatic logic [31:0] bp_b(input int t);
    return 32'h00FF_0011 + t;
  endfunction

  task automatic bp_test();
    int acc = 0;
    int emerged = 0;
    lat_en = 1'b0;
    out_ready = 1'b0;
    for (int ci = 0; ci < 12; ci++) begin
      if (ci == 6) out_ready = 1'b1;
      if (acc < 4) begin
        in_valid = 1'b1;
        in0 = bp_a(acc); in1 = bp_b(acc); in_split = MUL_SPLIT_FULL; in_tag = 4'(acc);
        cur_exp_prod = ref_prod(bp_a(acc), bp_b(acc), MUL_SPLIT_FULL);
        cur_exp_err  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (ci >= 2 && ci <= 5) begin
        check_eq("bp_in_ready",  64'(in_ready),  64'd0);
        check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        check_eq("bp_hold_prod", out_prod, ref_prod(bp_a(0), bp_b(0), MUL_SPLIT_FULL));
        check_eq("bp_hold_tag",  64'(out_tag),   64'd0);
      end
      if (ci == 5) check_eq("bp_accepts", 64'(acc), 64'd2);
      if (ci >= 6 && emerged < 4) begin
        check_eq("bp_stream_valid", 64'(out_valid), 64'd1);
        check_eq("bp_order",        64'(out_tag),   64'(emerged));
        emerged++;
      end
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    lat_en = 1'b1;
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  sp;
    logic [1:0]  pat [4];
    pat[0] = MUL_SPLIT_FULL; pat[1] = MUL_SPLIT_HALF;
    pat[2] = MUL_SPLIT_QUARTER; pat[3] = MUL_SPLIT_FULL;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_prod",  out_prod,       64'd0);
    check_eq("rst_out_split", 64'(out_split), 64'd0);
    check_eq("rst_out_tag",   64'(out_tag),   64'd0);
    check_eq("rst_out_err",   64'(out_err),   64'd0);
    check_eq("rst_in_ready",  64'(in_ready),  64'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed lane-split vectors
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, mul_split_from_precision(PRECISION_CONFIG_32B), 4'd1,
         64'hFFFF_FFFE_0000_0001);
    drain();
    send(32'h0003_FFFF, 32'h0005_FFFF, mul_split_from_precision(PRECISION_CONFIG_16B), 4'd2,
         64'h0000_000F_FFFE_0001);
    drain();
    send(32'h0403_0201, 32'h0807_0605, mul_split_from_precision(PRECISION_CONFIG_8B), 4'd3,
         64'h0020_0015_000C_0005);
    drain();

    // Back-pressure
    bp_test();

    // Interleaved splits, back to back, random operands
    for (int t = 0; t < 12; t++) begin
      a  = $urandom;
      b  = $urandom;
      sp = pat[t % 4];
      send(a, b, sp, 4'(t), ref_prod(a, b, sp));
    end
    drain();

    // Illegal split
    send(32'h1234_5678, 32'h9ABC_DEF0, 2'd3, 4'd9, 64'd0);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(32'h0000_0011, 32'h0000_0022, MUL_SPLIT_FULL, 4'd5, 64'h0000_0000_0000_0242);
    send(32'h0000_0033, 32'h0000_0044, MUL_SPLIT_FULL, 4'd6, 64'h0000_0000_0000_0D8C);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_flush_valid",    64'(out_valid), 64'd0);
    check_eq("rst_flush_prod",     out_prod,       64'd0);
    check_eq("rst_flush_in_ready", 64'(in_ready),  64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq("rst_release_in_ready", 64'(in_ready), 64'd1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check_eq("no_ghost_beat", 64'(out_valid), 64'd0);
    end

    // Pipeline still healthy after reset
    send(32'h0000_0101, 32'h0000_0202, MUL_SPLIT_QUARTER, 4'd7, 64'h0000_0000_0002_0002);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
